// File: rtl/reg_pkg.sv
// Shared types and default sizes for the scoreboarded register file.
package reg_pkg;

  localparam int unsigned DefaultDataW = 32;
  localparam int unsigned DefaultAddrW = 5;

  typedef enum logic {
    StRun,
    StClear
  } state_e;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-producer bits per register entry, with write-clear bypass on the two lookups.
module reg_scoreboard #(
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              alloc_i,
  input  logic [ADDR_W-1:0] alloc_addr_i,
  input  logic              wclr_i,
  input  logic [ADDR_W-1:0] wclr_addr_i,
  input  logic              bclr_i,
  input  logic [ADDR_W-1:0] bclr_idx_i,
  input  logic [ADDR_W-1:0] look_a_addr_i,
  input  logic [ADDR_W-1:0] look_b_addr_i,
  output logic              busy_a_o,
  output logic              busy_b_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0] r_pend;
  logic             w_alloc_ok;

  assign w_alloc_ok = alloc_i && !((ZERO_REG != 0) && (alloc_addr_i == '0));

  // Alloc is applied after the write-clear so it wins on a shared target.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pend <= '0;
    end else if (bclr_i) begin
      r_pend[bclr_idx_i] <= 1'b0;
    end else begin
      if (wclr_i) r_pend[wclr_addr_i] <= 1'b0;
      if (w_alloc_ok) r_pend[alloc_addr_i] <= 1'b1;
    end
  end

  function automatic logic busy_of(input logic [ADDR_W-1:0] a);
    logic b;
    if (bclr_i) b = 1'b1;
    else if ((ZERO_REG != 0) && (a == '0)) b = 1'b0;
    else if (wclr_i && !rst_i && (wclr_addr_i == a)) b = 1'b0;
    else b = r_pend[a];
    return b;
  endfunction

  assign busy_a_o = busy_of(look_a_addr_i);
  assign busy_b_o = busy_of(look_b_addr_i);

endmodule

// File: rtl/reg_file_sb.sv
// Two-read/one-write register file with per-entry pending bits and a sequenced bulk clear.
module reg_file_sb
  import reg_pkg::*;
#(
  parameter int unsigned DATA_W   = DefaultDataW,
  parameter int unsigned ADDR_W   = DefaultAddrW,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  output logic              ready_o,
  input  logic [ADDR_W-1:0] rs_addr_i,
  input  logic [ADDR_W-1:0] rt_addr_i,
  output logic [DATA_W-1:0] rs_data_o,
  output logic [DATA_W-1:0] rt_data_o,
  output logic              rs_busy_o,
  output logic              rt_busy_o,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] wd_addr_i,
  input  logic [DATA_W-1:0] wd_data_i,
  input  logic              alloc_i,
  input  logic [ADDR_W-1:0] alloc_addr_i
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  state_e            r_state, w_state_next;
  logic [ADDR_W-1:0] r_idx, w_idx_next;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              w_clearing, w_last, w_wr_ok;

  assign w_clearing = (r_state == StClear);
  assign w_last     = (r_idx == ADDR_W'(DEPTH - 1));
  assign w_wr_ok    = we_i && !((ZERO_REG != 0) && (wd_addr_i == '0));
  assign ready_o    = !w_clearing;

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    case (r_state)
      StRun: begin
        if (clr_i) begin
          w_state_next = StClear;
          w_idx_next   = '0;
        end
      end
      StClear: begin
        if (w_last) begin
          w_state_next = StRun;
          w_idx_next   = '0;
        end else begin
          w_idx_next = r_idx + ADDR_W'(1);
        end
      end
      default: w_state_next = StRun;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= StRun;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
    end else if (w_clearing) begin
      r_mem[r_idx] <= '0;
    end else if (w_wr_ok) begin
      r_mem[wd_addr_i] <= wd_data_i;
    end
  end

  // Bypass is suppressed while reset is held so every read returns zero.
  function automatic logic [DATA_W-1:0] rd_data(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] d;
    if (w_clearing || rst_i || ((ZERO_REG != 0) && (a == '0))) d = '0;
    else if (we_i && (wd_addr_i == a)) d = wd_data_i;
    else d = r_mem[a];
    return d;
  endfunction

  assign rs_data_o = rd_data(rs_addr_i);
  assign rt_data_o = rd_data(rt_addr_i);

  reg_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .alloc_i       (alloc_i),
    .alloc_addr_i  (alloc_addr_i),
    .wclr_i        (w_wr_ok),
    .wclr_addr_i   (wd_addr_i),
    .bclr_i        (w_clearing),
    .bclr_idx_i    (r_idx),
    .look_a_addr_i (rs_addr_i),
    .look_b_addr_i (rt_addr_i),
    .busy_a_o      (rs_busy_o),
    .busy_b_o      (rt_busy_o)
  );

endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, meaning address width; DEPTH = 2**ADDR_W entries.
REQ-003 SHALL have parameter ZERO_REG, default 1, meaning entry 0 is hardwired to zero when 1.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_i, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have port clr_i, input, 1: request a sequenced bulk clear.
REQ-007 SHALL have port ready_o, output, 1: high when not clearing.
REQ-008 SHALL have ports rs_addr_i and rt_addr_i, input, ADDR_W bits each: read addresses.
REQ-009 SHALL have ports rs_data_o and rt_data_o, output, DATA_W bits each: read data.
REQ-010 SHALL have ports rs_busy_o and rt_busy_o, output, 1 bit each: the read entry has a pending producer.
REQ-011 SHALL have ports we_i (1), wd_addr_i (ADDR_W) and wd_data_i (DATA_W), all input: write-back port.
REQ-012 SHALL have ports alloc_i (1) and alloc_addr_i (ADDR_W), both input: mark an entry pending.

Function
REQ-013 SHALL have two states, RUN and CLEAR, with RUN after reset.
REQ-014 SHALL, in RUN with we_i=1, write wd_data_i to entry wd_addr_i at the rising edge.
REQ-015 SHALL make read ports combinational, with write bypass: if we_i=1 and wd_addr_i equals the read address, output wd_data_i, else the stored entry.
REQ-016 SHALL, when ZERO_REG=1, always read entry 0 as 0 with busy 0, ignore writes to entry 0, and ignore allocs to entry 0; no bypass applies to entry 0.
REQ-017 SHALL set the pending bit of alloc_addr_i on an edge with alloc_i=1, and clear the pending bit of wd_addr_i on an edge with we_i=1.
REQ-018 SHALL give alloc priority when alloc and write target the same entry in the same cycle: data is written and the pending bit stays or becomes 1.
REQ-019 SHALL drive busy outputs combinationally: 0 if we_i=1 to that address this cycle (write-clear bypass), else the stored pending bit; alloc in the same cycle does not affect that cycle's busy.
REQ-020 SHALL let both read ports address the same entry and return identical data and busy.
REQ-021 SHALL, on clr_i=1 in RUN, enter CLEAR at the next edge, with index counter = 0 and ready_o=0.
REQ-022 SHALL, in CLEAR, zero data and pending bit of entry index at each edge, then increment index.
REQ-023 SHALL return from CLEAR to RUN at the edge that clears entry DEPTH-1, so ready_o is low for exactly DEPTH cycles.
REQ-024 SHALL, in CLEAR, ignore we_i, alloc_i and clr_i, drive both read data outputs to 0 and both busy outputs to 1.
REQ-025 SHALL, when clr_i and we_i/alloc_i are high in the same RUN cycle, perform that cycle's write/alloc; the clear then overwrites it.
REQ-026 SHALL let the index counter be ADDR_W bits wide; CLEAR exit is detected on index = DEPTH-1 without wrap.

Reset
REQ-027 SHALL, when rst_i is asserted, immediately (no clock needed) zero all entries and all pending bits, set the state to RUN and the index to 0.
REQ-028 SHALL, during reset, drive ready_o=1, with read data 0 and busy 0 for all addresses (subject to the same-cycle write bypass only after release).
REQ-029 SHALL let rst_i during CLEAR abort the clear and return to RUN.

Structure
REQ-030 SHALL place the state enum (RUN/CLEAR) and default DATA_W/ADDR_W constants in the shared package reg_pkg.
REQ-031 SHALL place the pending-bit array and busy logic in the sub-module reg_scoreboard (ports: clk_i, rst_i, alloc, write-clear, bulk-clear index, two lookups).

Verification
REQ-032 SHALL test this: write 0x0000_00AA to entry 5, then read rs_addr=5 -> 0xAA; same cycle rs_addr=5, we_i=1, wd_data=0x55 -> rs_data_o=0x55 (bypass).
REQ-033 SHALL test this: alloc entry 7, next cycle rs_addr=7 -> rs_busy_o=1; write entry 7 -> busy 0 that cycle and after.
REQ-034 SHALL test this: alloc and write entry 9 in the same cycle with data 0x1234 -> entry reads 0x1234 and busy stays 1.
REQ-035 SHALL test this: write 0xFFFF_FFFF to entry 0 with ZERO_REG=1 -> reads 0, busy 0.
REQ-036 SHALL test this: fill entries 1..31, pulse clr_i -> ready_o low exactly 32 cycles, reads 0/busy 1 meanwhile, all entries 0 afterwards; writes during CLEAR are lost.
REQ-037 SHALL test this: assert rst_i mid-CLEAR (index 10) with no clock edge -> ready_o=1 and all reads 0 immediately.
